// File: rtl/fe_rst_pkg.sv
// Shared definitions for the front-end reset sequencer: one-hot state
// constants, default timing parameters and the interval width.
package fe_rst_pkg;

   localparam int QUIET_DEF   = 4;
   localparam int GAP_DEF     = 16;
   localparam int TMOBITS_DEF = 17;
   localparam int INTERVAL_W  = 24;

   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_QWT  = 5'b00010,
      ST_STRT = 5'b00100,
      ST_RUN  = 5'b01000,
      ST_GAP  = 5'b10000
   } state_e;

endpackage

// File: rtl/fe_rst_timer.sv
// Periodic interval counter: counts while enabled, flags expiry at
// interval-1 and restarts from zero on expiry or an explicit clear.
module fe_rst_timer
   import fe_rst_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cnt_en,
   input  logic                  clr,
   input  logic [INTERVAL_W-1:0] interval,
   output logic                  expire
);

   logic [INTERVAL_W-1:0] cnt_q, cnt_d;

   // >= rather than == so a shrinking interval cannot strand the count
   assign expire = cnt_en && (cnt_q >= (interval - INTERVAL_W'(1)));

   always_comb begin
      cnt_d = cnt_q;
      if (clr || expire) begin
         cnt_d = '0;
      end else if (cnt_en) begin
         cnt_d = cnt_q + INTERVAL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fe_reset_ctrl.sv
// Front-end ASIC reset sequencer: quiesces triggering, starts the reset
// engine, hands it the command line and returns it on done or timeout.
module fe_reset_ctrl
   import fe_rst_pkg::*;
#(
   parameter int QUIET   = QUIET_DEF,
   parameter int GAP     = GAP_DEF,
   parameter int TMOBITS = TMOBITS_DEF
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic [INTERVAL_W-1:0] Interval,
   input  logic                  ReqExt,
   input  logic                  ClrErr,
   input  logic                  TrgBusy,
   input  logic                  CmdIdle,
   input  logic                  NormCmd,
   input  logic                  RstCmd,
   input  logic                  RstDone,
   output logic                  RstStart,
   output logic                  Hold,
   output logic                  CmdOut,
   output logic                  Active,
   output logic                  TmoErr,
   output logic [7:0]            RstCount
);

   localparam int QW = $clog2(QUIET + 1);
   localparam int GW = $clog2(GAP + 1);

   state_e             state_q, state_d;
   logic               req_q, req_d;
   logic               pend_q, pend_d;
   logic               sel_q, sel_d;
   logic               tmo_err_q, tmo_err_d;
   logic [7:0]         rst_count_q, rst_count_d;
   logic [QW-1:0]      quiet_q, quiet_d;
   logic [TMOBITS-1:0] tmo_q, tmo_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic               in_idle, go, timer_en, expire;

   assign in_idle  = (state_q == ST_IDLE);
   assign go       = in_idle && (req_q || pend_q);
   assign timer_en = in_idle && Enable && (Interval != '0);

   fe_rst_timer u_timer (
      .clk      (Clock),
      .rst_n    (Reset),
      .cnt_en   (timer_en),
      .clr      (go),
      .interval (Interval),
      .expire   (expire)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = 1'b0;
      pend_d      = pend_q;
      sel_d       = sel_q;
      tmo_err_d   = tmo_err_q;
      rst_count_d = rst_count_q;
      quiet_d     = '0;
      tmo_d       = tmo_q;
      gap_d       = '0;

      if (ClrErr) tmo_err_d = 1'b0;
      if (!in_idle && ReqExt) pend_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            // a request landing while already leaving merges into this sequence
            if (go) state_d = ST_QWT;
            else    req_d   = expire || ReqExt;
         end
         ST_QWT: begin
            if (quiet_q == QW'(QUIET))      state_d = ST_STRT;
            else if (!TrgBusy && CmdIdle)   quiet_d = quiet_q + QW'(1);
         end
         ST_STRT: begin
            state_d = ST_RUN;
            sel_d   = 1'b1;
            tmo_d   = '0;
            if (!ReqExt) pend_d = 1'b0;
         end
         ST_RUN: begin
            tmo_d = tmo_q + TMOBITS'(1);
            if (RstDone) begin
               state_d = ST_GAP;
               if (rst_count_q != 8'hFF) rst_count_d = rst_count_q + 8'd1;
            end else if (&tmo_d) begin
               state_d   = ST_GAP;
               tmo_err_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q == GW'(GAP)) begin
               state_d = ST_IDLE;
               sel_d   = 1'b0;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         pend_q      <= 1'b0;
         sel_q       <= 1'b0;
         tmo_err_q   <= 1'b0;
         rst_count_q <= '0;
         quiet_q     <= '0;
         tmo_q       <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         pend_q      <= pend_d;
         sel_q       <= sel_d;
         tmo_err_q   <= tmo_err_d;
         rst_count_q <= rst_count_d;
         quiet_q     <= quiet_d;
         tmo_q       <= tmo_d;
         gap_q       <= gap_d;
      end
   end

   // sel_q only changes on state edges, never mid serializer command
   assign CmdOut   = sel_q ? RstCmd : NormCmd;
   assign RstStart = (state_q == ST_STRT);
   assign Hold     = !in_idle;
   assign Active   = (state_q == ST_STRT) || (state_q == ST_RUN) || (state_q == ST_GAP);
   assign TmoErr   = tmo_err_q;
   assign RstCount = rst_count_q;

endmodule
